// File: rtl/coproc_pkg.sv
// Shared encodings for the coprocessor channel arbiter: FSM states, requester IDs
// and the data word returned on a timed-out transaction.
package coproc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic SEL_LOGIC = 1'b0;
   localparam logic SEL_PY    = 1'b1;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD0001;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time is chosen.
// Bit 0 of i_req is the logic engine, bit 1 is Python execution.
module rr_arb2
   import coproc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic       o_gnt,
   output logic       o_sel
);

   logic r_last;

   always_comb begin
      o_gnt = i_en & (|i_req);
      if (&i_req) o_sel = ~r_last;
      else        o_sel = i_req[1];
   end

   // Resetting to SEL_PY lets the logic engine win the first tie.
   always_ff @(posedge clk) begin
      if (rst)        r_last <= SEL_PY;
      else if (o_gnt) r_last <= o_sel;
   end

endmodule

// File: rtl/coproc_arbiter.sv
// Shares one external coprocessor channel between the logic engine and Python execution.
// Optional wait-state timeout is enabled by defining COPROC_TIMEOUT_EN.
module coproc_arbiter
   import coproc_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              logic_req,
   input  logic [DATA_W-1:0] logic_addr,
   output logic              logic_done,
   output logic [DATA_W-1:0] logic_data,
   output logic              logic_err,
   input  logic              py_req,
   input  logic [DATA_W-1:0] py_addr,
   output logic              py_done,
   output logic [DATA_W-1:0] py_data,
   output logic              py_err,
   output logic              cop_req,
   output logic              cop_sel,
   output logic [DATA_W-1:0] cop_addr,
   input  logic              cop_ack,
   input  logic [DATA_W-1:0] cop_data,
   output logic              busy,
   output logic [CNT_W-1:0]  logic_grants,
   output logic [CNT_W-1:0]  py_grants,
   output logic [7:0]        timeouts
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (&v) ? v : v + 8'd1;
   endfunction

   state_t              r_state;
   state_t              w_next;
   logic                r_sel;
   logic [DATA_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;
   logic                r_err;
   logic [CNT_W-1:0]    r_logic_grants;
   logic [CNT_W-1:0]    r_py_grants;
   logic                w_gnt;
   logic                w_gnt_sel;
   logic                w_timeout;
   logic                w_resp;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .i_en  (r_state == IDLE),
      .i_req ({py_req, logic_req}),
      .o_gnt (w_gnt),
      .o_sel (w_gnt_sel)
   );

`ifdef COPROC_TIMEOUT_EN
   localparam int WC_W = $clog2(TIMEOUT_CYCLES);

   logic [WC_W-1:0] r_wait_cnt;
   logic [7:0]      r_timeouts;

   // An ack in the terminal cycle takes priority over the timeout.
   assign w_timeout = (r_state == WAIT) && !cop_ack &&
                      (r_wait_cnt == WC_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt <= '0;
         r_timeouts <= 8'd0;
      end else begin
         if (w_gnt)                             r_wait_cnt <= '0;
         else if (r_state == WAIT && !cop_ack)  r_wait_cnt <= r_wait_cnt + WC_W'(1);
         if (w_timeout)                         r_timeouts <= sat_inc8(r_timeouts);
      end
   end

   assign timeouts = r_timeouts;
`else
   assign w_timeout = 1'b0;
   assign timeouts  = 8'd0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_gnt) w_next = WAIT;
         WAIT:    if (cop_ack || w_timeout) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_resp     = (r_state == RESP);
      busy       = (r_state != IDLE);
      cop_req    = (r_state == WAIT);
      cop_sel    = r_sel;
      cop_addr   = r_addr;
      logic_done = w_resp && (r_sel == SEL_LOGIC);
      py_done    = w_resp && (r_sel == SEL_PY);
      logic_data = logic_done ? r_data : '0;
      logic_err  = logic_done ? r_err  : 1'b0;
      py_data    = py_done    ? r_data : '0;
      py_err     = py_done    ? r_err  : 1'b0;
   end

   // Grant latches, result latch and usage counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel          <= SEL_LOGIC;
         r_addr         <= '0;
         r_data         <= '0;
         r_err          <= 1'b0;
         r_logic_grants <= '0;
         r_py_grants    <= '0;
      end else begin
         if (w_gnt) begin
            r_sel  <= w_gnt_sel;
            r_addr <= (w_gnt_sel == SEL_PY) ? py_addr : logic_addr;
            if (w_gnt_sel == SEL_PY) r_py_grants    <= sat_inc_cnt(r_py_grants);
            else                     r_logic_grants <= sat_inc_cnt(r_logic_grants);
         end
         if (r_state == WAIT) begin
            if (cop_ack) begin
               r_data <= cop_data;
               r_err  <= 1'b0;
            end else if (w_timeout) begin
               r_data <= DATA_W'(TIMEOUT_DATA);
               r_err  <= 1'b1;
            end
         end
      end
   end

   assign logic_grants = r_logic_grants;
   assign py_grants    = r_py_grants;

endmodule

// File: tb/tb_coproc_arbiter.sv
// Self-checking bench for coproc_arbiter: vector table plus hand-written corner sequences,
// with completions checked against a scoreboard queue. Timeout checks need COPROC_TIMEOUT_EN.
module tb_coproc_arbiter;

   localparam int DW = 32;
   localparam int CW = 3;
   localparam logic [CW-1:0] CMAX = '1;

   logic          clk = 1'b0;
   logic          rst;
   logic          logic_req, py_req, cop_ack;
   logic [DW-1:0] logic_addr, py_addr, cop_data;
   logic          logic_done, logic_err, py_done, py_err;
   logic [DW-1:0] logic_data, py_data, cop_addr;
   logic          cop_req, cop_sel, busy;
   logic [CW-1:0] logic_grants, py_grants;
   logic [7:0]    timeouts;

   coproc_arbiter #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .logic_req(logic_req), .logic_addr(logic_addr), .logic_done(logic_done),
      .logic_data(logic_data), .logic_err(logic_err),
      .py_req(py_req), .py_addr(py_addr), .py_done(py_done),
      .py_data(py_data), .py_err(py_err),
      .cop_req(cop_req), .cop_sel(cop_sel), .cop_addr(cop_addr),
      .cop_ack(cop_ack), .cop_data(cop_data),
      .busy(busy), .logic_grants(logic_grants), .py_grants(py_grants), .timeouts(timeouts)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          sel;
      logic [31:0] data;
      bit          err;
   } exp_t;

   typedef struct {
      bit          sel;
      logic [31:0] addr;
      logic [31:0] data;
      int          dly;
      bit          resp_ack;
   } vec_t;

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [CW-1:0] exp_lg, exp_pg;
   logic [7:0]    exp_to;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
      return (v == CMAX) ? v : v + 1'b1;
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cop_req"}, cop_req, 0);
      chk({tag, "_cop_sel"}, cop_sel, 0);
      chk({tag, "_cop_addr"}, cop_addr, 0);
      chk({tag, "_dones"}, {logic_done, py_done}, 0);
      chk({tag, "_datas"}, logic_data | py_data, 0);
      chk({tag, "_errs"}, {logic_err, py_err}, 0);
      chk({tag, "_grants"}, {logic_grants, py_grants}, 0);
      chk({tag, "_timeouts"}, timeouts, 0);
   endtask

   task automatic wait_done(input int budget);
      int   n = 0;
      exp_t e;
      while (!(logic_done || py_done) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!(logic_done || py_done)) begin
         chk("done_arrival", 0, 1);
      end else if (sb.size() == 0) begin
         chk("unexpected_done", {logic_done, py_done}, 0);
      end else begin
         e = sb.pop_front();
         chk("done_sel", {py_done, logic_done}, e.sel ? 2'b10 : 2'b01);
         chk("done_data", e.sel ? py_data : logic_data, e.data);
         chk("done_err", e.sel ? py_err : logic_err, e.err);
         chk("other_data", e.sel ? logic_data : py_data, 0);
      end
   endtask

   // One complete transaction, entered and left on a negedge with the DUT idle.
   task automatic do_txn(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                         input int dly, input bit drop, input bit resp_ack);
      bit held = 1'b1;
      if (sel) begin py_req = 1'b1; py_addr = addr; end
      else begin logic_req = 1'b1; logic_addr = addr; end
      @(negedge clk);
      chk("cop_req_rise", cop_req, 1);
      chk("cop_sel", cop_sel, sel);
      chk("cop_addr", cop_addr, addr);
      chk("busy_wait", busy, 1);
      if (sel) exp_pg = sat(exp_pg); else exp_lg = sat(exp_lg);
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         if (!cop_req || cop_sel != sel || cop_addr != addr) held = 1'b0;
      end
      if (dly > 0) chk("cop_req_held", held, 1);
      cop_ack  = 1'b1;
      cop_data = data;
      sb.push_back('{sel, data, 1'b0});
      @(negedge clk);
      cop_ack  = 1'b0;
      cop_data = $urandom;
      wait_done(3);
      if (resp_ack) begin
         cop_ack  = 1'b1;
         cop_data = $urandom;
      end
      if (drop) begin
         if (sel) py_req = 1'b0; else logic_req = 1'b0;
      end
      @(negedge clk);
      cop_ack = 1'b0;
      chk("done_pulse_end", {logic_done, py_done}, 0);
      chk("cop_req_resp", cop_req, 0);
      chk("logic_grants", logic_grants, exp_lg);
      chk("py_grants", py_grants, exp_pg);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[4];
      bit   seen;
      int   cnt;

      vt[0] = '{1'b0, 32'h0000_0040, 32'hABCD_1234, 2,  1'b0};
      vt[1] = '{1'b1, 32'h0000_1000, 32'h1234_5678, 15, 1'b0};
      vt[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 0,  1'b0};
      vt[3] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1,  1'b1};

      rst = 1'b1; logic_req = 1'b0; py_req = 1'b0; cop_ack = 1'b0;
      logic_addr = '0; py_addr = '0; cop_data = '0;
      exp_lg = '0; exp_pg = '0; exp_to = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++)
         do_txn(vt[i].sel, vt[i].addr, vt[i].data, vt[i].dly, 1'b1, vt[i].resp_ack);
      @(negedge clk);
      chk("busy_after_resp_ack", busy, 0);
      chk("table_logic_grants", logic_grants, 2);
      chk("table_py_grants", py_grants, 2);

      // Spurious ack while idle.
      cop_ack = 1'b1; cop_data = 32'h5A5A_5A5A;
      @(negedge clk);
      cop_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack_busy", busy, 0);
      chk("idle_ack_dones", {logic_done, py_done}, 0);
      chk("idle_ack_grants", {logic_grants, py_grants}, {exp_lg, exp_pg});

      // Continuous contention right after reset: logic first, then strict alternation.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; exp_lg = '0; exp_pg = '0;
      logic_addr = 32'h100; py_addr = 32'h200;
      logic_req = 1'b1; py_req = 1'b1;
      for (int i = 0; i < 4; i++)
         do_txn(i[0], i[0] ? 32'h200 : 32'h100, 32'hC000_0000 + i, i, 1'b0, 1'b0);
      logic_req = 1'b0; py_req = 1'b0;
      chk("contend_logic_grants", logic_grants, 2);
      chk("contend_py_grants", py_grants, 2);

      // Reset in the middle of a wait: abandoned without a done pulse.
      @(negedge clk);
      logic_addr = 32'h55; logic_req = 1'b1;
      @(negedge clk);
      chk("rst_wait_cop_req", cop_req, 1);
      rst = 1'b1; logic_req = 1'b0;
      @(negedge clk);
      check_all_zero("rst_wait");
      rst = 1'b0; exp_lg = '0; exp_pg = '0; exp_to = '0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (logic_done || py_done || busy) seen = 1'b1;
      end
      chk("rst_wait_no_done", seen, 0);

`ifdef COPROC_TIMEOUT_EN
      logic_addr = 32'h77; logic_req = 1'b1;
      sb.push_back('{1'b0, 32'hDEAD_0001, 1'b1});
      exp_lg = sat(exp_lg);
      @(negedge clk);
      cnt = 0;
      while (cop_req && cnt < 50) begin
         cnt++;
         @(negedge clk);
      end
      chk("timeout_wait_cycles", cnt, 8);
      wait_done(2);
      chk("timeouts_count", timeouts, 1);
      logic_req = 1'b0;
      cop_ack = 1'b1; cop_data = 32'h0BAD_0BAD;
      @(negedge clk);
      cop_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_busy", busy, 0);
      chk("late_ack_dones", {logic_done, py_done}, 0);
      do_txn(1'b0, 32'h78, 32'h600D_0001, 3, 1'b1, 1'b0);
      chk("timeouts_after_ok", timeouts, 1);
`else
      cnt = 0;
      chk("timeouts_tied", timeouts, cnt);
`endif

      // Grant counter saturation.
      for (int i = 0; i < 10; i++)
         do_txn(1'b0, 32'h300 + i, 32'h7000_0000 + i, 0, 1'b1, 1'b0);
      chk("logic_grants_sat", logic_grants, CMAX);
      chk("scoreboard_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/coproc_arbiter.md
Name: coproc_arbiter

Overview:
- Shares one external coprocessor channel between the CPU's two off-core requesters: the logic engine (ORACLE) and Python execution (PYEXEC).
- Round-robin arbitration, one transaction outstanding at a time, per-requester done/data/error return, saturating usage counters.
- Sits between the thiele_cpu logic_*/py_* ports and the single external engine channel.

Parameters:
- DATA_W, 32, width of address and result data.
- CNT_W, 16, width of per-requester grant counters.
- TIMEOUT_CYCLES, 64, WAIT-state cycles before an error completion (used only with the optional feature); minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- logic_req  in  1  logic requester request; level, held until logic_done.
- logic_addr  in  DATA_W  logic request address.
- logic_done  out  1  one-cycle completion pulse.
- logic_data  out  DATA_W  result; valid while logic_done=1.
- logic_err  out  1  error flag; valid while logic_done=1.
- py_req  in  1  Python requester request; level.
- py_addr  in  DATA_W  Python code address.
- py_done  out  1  one-cycle completion pulse.
- py_data  out  DATA_W  result; valid while py_done=1.
- py_err  out  1  error flag; valid while py_done=1.
- cop_req  out  1  downstream request, held until cop_ack is sampled.
- cop_sel  out  1  0 = logic, 1 = Python; stable while cop_req=1.
- cop_addr  out  DATA_W  downstream address; stable while cop_req=1.
- cop_ack  in  1  downstream acknowledge; single-cycle pulse.
- cop_data  in  DATA_W  downstream result; sampled in the cop_ack cycle.
- busy  out  1  high in any state other than IDLE.
- logic_grants  out  CNT_W  saturating count of logic grants.
- py_grants  out  CNT_W  saturating count of Python grants.
- timeouts  out  8  saturating count of timeouts; reads 0 when the optional feature is off.

Behaviour:
- Reset: every output is 0. State is IDLE. last_grant=1, so logic wins the first tie.
- States: IDLE, WAIT, RESP.
- IDLE:
  - One request high: grant it.
  - Both high: grant the requester other than last_grant.
  - On grant: latch sel and addr, set last_grant, increment that requester's grant counter (saturating at all-ones), go to WAIT.
  - Neither high: stay in IDLE.
- WAIT:
  - cop_req=1, with cop_sel/cop_addr from the latched values. cop_req rises exactly one cycle after the grant cycle.
  - When cop_ack=1: latch cop_data, err=0, go to RESP.
  - Requester inputs are ignored in WAIT. Dropping req does not abort the transaction.
- RESP:
  - cop_req=0.
  - The granted requester's done=1 for exactly one cycle, with data/err driven from the latch. The other requester's done/data/err stay 0.
  - Next state is IDLE.
  - Minimum transaction is 3 cycles from grant to the next possible grant.
- Outputs data/err are registered and forced to 0 when done=0.
- cop_ack while cop_req=0 (IDLE or RESP) is ignored, with no side effect.
- Requester rule: a requester still holding req after done is re-arbitrated in IDLE. Fairness guarantees alternation under continuous contention.
- cop_sel/cop_addr hold their last value outside WAIT.
- rst asserted in any state:
  - Return to IDLE next cycle, clear counters and outputs.
  - Any in-flight transaction is abandoned with no done pulse.

Optional Feature:
- Macro: COPROC_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack: go to RESP with data=32'hDEAD0001, err=1, and increment timeouts (saturating at 255).
  - Ack in the terminal cycle wins: normal completion, err=0.
  - A late ack arriving after the timeout is ignored.
- Undefined: no counter logic, WAIT lasts indefinitely, timeouts tied to 0.

Decomposition:
- Shared package (coproc_pkg):
  - State encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Requester IDs: SEL_LOGIC=0, SEL_PY=1.
  - TIMEOUT_DATA constant 32'hDEAD0001.
- Sub-module rr_arb2: 2-way round-robin grant logic plus the last_grant register.
- FSM, latches, counters and timeout stay in coproc_arbiter.

Test Plan:
- Single logic request: logic_req=1, addr=0x40; ack 2 cycles after cop_req with cop_data=0xABCD1234 -> cop_req/cop_sel=0/cop_addr=0x40, then logic_done pulse with data 0xABCD1234, err=0, logic_grants=1.
- Simultaneous requests after reset: both req high at the same edge -> logic granted first, then py, alternating for 4 transactions -> grants 2/2.
- Python ack with data 0x12345678 delayed 15 cycles -> cop_req held high all 15 cycles, py_done data 0x12345678, logic_done stays 0.
- Spurious cop_ack in IDLE and in RESP -> no done pulse, counters unchanged.
- COPROC_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> logic_done with data 0xDEAD0001, err=1, timeouts=1. A later ack is ignored, and the next request completes normally.
- rst during WAIT -> IDLE next cycle, cop_req=0, no done pulse, counters 0.
